seq_div16x8: RTL and testbench

- Multi-cycle restoring divider: 16-bit dividend / 8-bit divisor -> 16-bit quotient + 8-bit remainder.
- Inverse companion to the pipelined 8x8 multiplier; dividing a product by one operand recovers the other.
- One quotient bit per cycle, MSB first.
- Valid/ready handshake on both sides; sits beside the multiplier in the arithmetic datapath.

---
 rtl/seq_div16x8.sv | 134 +++++++++++++
 tb/tb_seq_div16x8.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_div16x8.sv
`default_nettype none
// ============================================================================
// Module      : seq_div16x8
// Description : Multi-cycle restoring divider, 16-bit unsigned dividend by
//               8-bit unsigned divisor, one quotient bit per cycle MSB first,
//               valid/ready handshake on operand and result sides.
//               Optional macro DIV_ZERO_FAST_EN: a zero divisor finishes one
//               cycle after accept instead of running all 16 iterations.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_div16x8 #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quot,
  output logic [VW-1:0] rem,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] c_last = CW'(DW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  // r_work starts as the dividend and shifts left once per iteration; the
  // vacated LSBs collect quotient bits, so after DW steps it holds the quotient.
  logic [DW-1:0] r_work;
  logic [VW-1:0] r_divisor;
  logic [VW-1:0] r_dvd_lo;
  logic [VW-1:0] r_part;
  logic [CW-1:0] r_cnt;

  logic [VW:0]   w_shift;
  logic          w_ge;
  logic [VW-1:0] w_part_next;
  logic [DW-1:0] w_work_next;
  logic          w_last;
  logic          w_zero;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  // The 9-bit shifted value only carries a set top bit transiently; once the
  // divisor is subtracted the remainder always fits back into VW bits.
  always_comb begin
    w_shift     = {r_part, r_work[DW-1]};
    w_ge        = w_shift[VW] | (w_shift[VW-1:0] >= r_divisor);
    w_part_next = w_ge ? (w_shift[VW-1:0] - r_divisor) : w_shift[VW-1:0];
    w_work_next = {r_work[DW-2:0], w_ge};
    w_last      = (r_cnt == c_last);
    w_zero      = (r_divisor == '0);
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next_state = S_BUSY;
      S_BUSY:  if (w_last) w_next_state = S_DONE;
      S_DONE:  if (out_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work      <= '0;
      r_divisor   <= '0;
      r_dvd_lo    <= '0;
      r_part      <= '0;
      r_cnt       <= '0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work      <= dividend;
            r_divisor   <= divisor;
            r_dvd_lo    <= dividend[VW-1:0];
            r_part      <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_ZERO_FAST_EN
            // A zero divisor jumps straight to the final iteration, so the
            // forced result appears one cycle after accept.
            r_cnt       <= (divisor == '0) ? c_last : '0;
`else
            r_cnt       <= '0;
`endif
          end
        end
        S_BUSY: begin
          r_work <= w_work_next;
          r_part <= w_part_next;
          r_cnt  <= r_cnt + CW'(1);
          if (w_last) begin
            // The zero-divisor result is forced rather than left to the
            // arithmetic, so it is the same whichever path produced it.
            quot        <= w_zero ? {DW{1'b1}} : w_work_next;
            rem         <= w_zero ? r_dvd_lo : w_part_next;
            div_by_zero <= w_zero;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_div16x8.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_div16x8
// Description : Self-checking bench for seq_div16x8: directed vector table,
//               handshake / reset corner sequences and random operands
//               checked against a plain-arithmetic division model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_div16x8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] quot;
  logic [7:0]  rem;
  logic        div_by_zero;

  int checks = 0;
  int failures = 0;

`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 16;
`endif

  seq_div16x8 #(.DW(16), .VW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quot       (quot),
    .rem        (rem),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer division with the zero-divisor convention.
  task automatic ref_div(input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] q, output logic [7:0] r,
                         output logic dz, output int lat);
    if (b == 8'd0) begin
      q = 16'hFFFF; r = a[7:0]; dz = 1'b1; lat = ZLAT;
    end else begin
      q = a / b; r = 8'(a % b); dz = 1'b0; lat = 16;
    end
  endtask

  task automatic accept(input logic [15:0] a, input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_ready", in_ready, 1);
    dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("busy_not_ready", in_ready, 0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("done_timeout", out_valid, 1);
  endtask

  task automatic check_res(input string nm, input logic [15:0] q, input logic [7:0] r, input logic dz);
    chk({nm, "_quot"}, quot, q);
    chk({nm, "_rem"}, rem, r);
    chk({nm, "_dz"}, div_by_zero, dz);
  endtask

  task automatic handshake(input logic [15:0] q);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("hs_valid_low", out_valid, 0);
    chk("hs_quot_kept", quot, q);
  endtask

  vec_t tv[6];

  initial begin
    int          lat;
    int          seen;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        edz;
    int          elat;
    logic [15:0] ra;
    logic [7:0]  rb;

    // 0xD3 * 0x5B = 0x4B01, so dividing the product by 0x5B recovers 0xD3.
    tv[0] = '{16'h3A2B, 8'h07, 16'h084F, 8'h02, 1'b0};
    tv[1] = '{16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0};
    tv[2] = '{16'h0064, 8'hC8, 16'h0000, 8'h64, 1'b0};
    tv[3] = '{16'h4B01, 8'h5B, 16'h00D3, 8'h00, 1'b0};
    tv[4] = '{16'h1234, 8'h00, 16'hFFFF, 8'h34, 1'b1};
    tv[5] = '{16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0};

    // Reset held from time zero.
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quot", quot, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    // Directed table.
    foreach (tv[i]) begin
      accept(tv[i].a, tv[i].b);
      wait_done(lat);
      chk($sformatf("vec%0d_latency", i), lat, tv[i].b == 8'd0 ? ZLAT : 16);
      check_res($sformatf("vec%0d", i), tv[i].q, tv[i].r, tv[i].dz);
      handshake(tv[i].q);
    end

    // Busy-ignore and backpressure.
    accept(16'h3A2B, 8'h07);
    repeat (3) begin @(posedge clk); #1; end
    dividend = 16'hFFFF; divisor = 8'h01; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("busy_ignore_ready", in_ready, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat);
    check_res("bp", 16'h084F, 8'h02, 1'b0);
    for (int k = 0; k < 5; k++) begin
      dividend = 16'h5555; divisor = 8'h03; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_quot", quot, 16'h084F);
      chk("bp_hold_rem", rem, 8'h02);
      chk("bp_no_accept", in_ready, 0);
    end
    in_valid = 1'b0;

    // Asynchronous reset mid-cycle while holding a result.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_quot", quot, 0);
    chk("async_rst_rem", rem, 0);
    chk("async_rst_ready", in_ready, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready, 1);

    // Reset in the middle of an operation discards it.
    accept(16'hBEEF, 8'h13);
    repeat (7) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midop_rst_no_valid", seen, 0);
    accept(16'h0100, 8'h10);
    wait_done(lat);
    chk("after_rst_latency", lat, 16);
    check_res("after_rst", 16'h0010, 8'h00, 1'b0);
    handshake(16'h0010);

    // Random operands against the arithmetic model.
    for (int n = 0; n < 30; n++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      ref_div(ra, rb, eq, er, edz, elat);
      accept(ra, rb);
      wait_done(lat);
      chk("rand_latency", lat, elat);
      check_res("rand", eq, er, edz);
      handshake(eq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
